// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - RV32I load/store unit: one request at a time, single-cycle RAM access, extended load response.
// Optional RISCV_LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module riscv_lsu #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_MEM     = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [WORD_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_LENGTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [WORD_LENGTH-1:0] ram_addr,
  output logic                   ram_write_en,
  output logic [WORD_LENGTH-1:0] ram_wdata,
  output logic [1:0]             ram_mask_sel,
  input  logic [WORD_LENGTH-1:0] ram_dout
);

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_X = 2'b10;

  localparam logic [WORD_LENGTH:0] MEM_LIMIT = (WORD_LENGTH+1)'(NUM_MEM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   we_q, we_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [WORD_LENGTH-1:0] addr_q, addr_d;
  logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
  logic [WORD_LENGTH-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [2:0]             req_size;
  logic [WORD_LENGTH:0]   req_end;
  logic                   range_bad;
  logic                   funct_bad;
  logic                   misalign_bad;
  logic                   req_illegal;
  logic [WORD_LENGTH-1:0] load_ext;

  // Access size; funct3[1:0]=11 is rejected by funct_bad so its size is irrelevant.
  always_comb begin
    req_size = 3'd4;
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
  end

  // One extra bit keeps addresses near the top of the space from wrapping past the limit.
  assign req_end   = {1'b0, req_addr} + {{(WORD_LENGTH-2){1'b0}}, req_size};
  assign range_bad = (req_end > MEM_LIMIT);

  always_comb begin
    funct_bad = 1'b0;
    if (req_we) begin
      funct_bad = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) && (req_funct3 != 3'b010);
    end else begin
      funct_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end
  end

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  always_comb begin
    misalign_bad = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misalign_bad = req_addr[0];
      2'b10:   misalign_bad = (req_addr[1:0] != 2'b00);
      default: misalign_bad = 1'b0;
    endcase
  end
`else
  assign misalign_bad = 1'b0;
`endif

  assign req_illegal = range_bad || funct_bad || misalign_bad;

  // RAM returns the addressed byte in lane 0, so extraction always starts at bit 0.
  always_comb begin
    load_ext = ram_dout;
    case (funct3_q)
      3'b000:  load_ext = {{(WORD_LENGTH-8){ram_dout[7]}}, ram_dout[7:0]};
      3'b001:  load_ext = {{(WORD_LENGTH-16){ram_dout[15]}}, ram_dout[15:0]};
      3'b100:  load_ext = {{(WORD_LENGTH-8){1'b0}}, ram_dout[7:0]};
      3'b101:  load_ext = {{(WORD_LENGTH-16){1'b0}}, ram_dout[15:0]};
      default: load_ext = ram_dout;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = req_illegal;
          state_d  = req_illegal ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = we_q ? '0 : load_ext;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // RAM port depends only on registered state, so req_* never glitches through to the RAM.
  always_comb begin
    ram_addr     = '0;
    ram_write_en = 1'b0;
    ram_wdata    = '0;
    ram_mask_sel = MASK_X;
    if (state_q == ACCESS) begin
      ram_addr     = addr_q;
      ram_write_en = we_q;
      ram_wdata    = we_q ? wdata_q : '0;
      case (funct3_q[1:0])
        2'b00:   ram_mask_sel = MASK_B;
        2'b01:   ram_mask_sel = MASK_H;
        default: ram_mask_sel = MASK_X;
      endcase
    end
  end

endmodule
